// File: rtl/pe_mac_ctrl_if.sv
// Handshake and pe_core drive bundle for pe_mac_ctrl.
// master = job source / operand feeder / result sink / pe_core model; slave = controller.
interface pe_mac_ctrl_if #(
  parameter int W_IN  = 8,
  parameter int W_ACC = 24,
  parameter int W_LEN = 8
) ();
  logic             start;
  logic [W_LEN-1:0] len;
  logic             relu_en;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [W_IN-1:0]  op_a;
  logic [W_IN-1:0]  op_b;
  logic             pe_en;
  logic             reg_reset;
  logic             mode_sel;
  logic [W_IN-1:0]  a_mul;
  logic [W_IN-1:0]  b_mul;
  logic [W_ACC-1:0] pe_results;
  logic             res_valid;
  logic             res_ready;
  logic [W_ACC-1:0] res_data;

  modport master (
    output start, len, relu_en, op_valid, op_a, op_b, pe_results, res_ready,
    input  busy, op_ready, pe_en, reg_reset, mode_sel, a_mul, b_mul, res_valid, res_data
  );

  modport slave (
    input  start, len, relu_en, op_valid, op_a, op_b, pe_results, res_ready,
    output busy, op_ready, pe_en, reg_reset, mode_sel, a_mul, b_mul, res_valid, res_data
  );
endinterface

// File: rtl/pe_mac_ctrl.sv
// Sequences one dot-product job through pe_core: clear, stream len operand pairs, drain PE_LAT+1.
// Result valid len+5 cycles after CLEAR with no bubbles; held in DONE until res_ready.
module pe_mac_ctrl #(
  parameter int W_IN   = 8,
  parameter int W_ACC  = 24,
  parameter int W_LEN  = 8,
  parameter int PE_LAT = 3
) (
  input logic         clk,
  input logic         reset,
  pe_mac_ctrl_if.slave bus
);
  localparam int W_DR = $clog2(PE_LAT + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [W_LEN-1:0] len_q, len_d;
  logic [W_LEN-1:0] cnt_q, cnt_d;
  logic [W_DR-1:0]  drain_q, drain_d;
  logic             mode_q, mode_d;
  logic [W_ACC-1:0] res_q, res_d;
  logic             accept;

  assign accept = (state_q == S_RUN) && bus.op_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          len_d   = bus.len;
          mode_d  = bus.relu_en;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        drain_d = '0;
        // Empty job: pe_core output is stale, so the result is forced to zero.
        if (len_q == '0) begin
          state_d = S_DONE;
          res_d   = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + W_LEN'(1);
          // Compare against len-1 so len = 2^W_LEN-1 finishes without the counter wrapping.
          if (cnt_q == len_q - W_LEN'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == W_DR'(PE_LAT)) begin
          state_d = S_DONE;
          res_d   = bus.pe_results;
        end else begin
          drain_d = drain_q + W_DR'(1);
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.op_ready  = (state_q == S_RUN);
  assign bus.pe_en     = accept;
  assign bus.reg_reset = (state_q == S_CLEAR);
  assign bus.mode_sel  = mode_q;
  assign bus.a_mul     = bus.op_a;
  assign bus.b_mul     = bus.op_b;
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res_data  = res_q;
endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Randomized scoreboard bench for pe_mac_ctrl with a behavioural pe_core model
// (accumulate a*b, PE_LAT update latency, ReLU on output when mode_sel).
module tb_pe_mac_ctrl;
  localparam int W_IN = 8, W_ACC = 24, W_LEN = 8, PE_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   rdy_mode = 0;
  int   a_arr [256];
  int   b_arr [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_mac_ctrl_if #(.W_IN(W_IN), .W_ACC(W_ACC), .W_LEN(W_LEN)) bus ();

  pe_mac_ctrl #(.W_IN(W_IN), .W_ACC(W_ACC), .W_LEN(W_LEN), .PE_LAT(PE_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // pe_core model: not cleared by controller reset, only by reg_reset.
  logic signed [W_ACC-1:0] acc = '0, d1 = '0, d2 = '0;
  logic signed [W_ACC-1:0] prod;
  assign prod = W_ACC'($signed({1'b0, bus.a_mul})) * W_ACC'($signed(bus.b_mul));
  always @(posedge clk) begin
    if (bus.reg_reset) acc <= '0;
    else if (bus.pe_en) acc <= acc + prod;
    d1 <= acc;
    d2 <= d1;
  end
  assign bus.pe_results = (bus.mode_sel && d2[W_ACC-1]) ? '0 : d2;

  typedef struct {
    logic [W_ACC-1:0] data;
    int npe;
    int abs_res;
    int abs_pe;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int n, input bit relu, input int s_cyc);
    exp_t   e;
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(a_arr[i]) * longint'(b_arr[i]);
    e.data    = (relu && s < 0) ? '0 : W_ACC'(s);
    e.npe     = n;
    e.abs_res = (s_cyc < 0) ? -1 : s_cyc + ((n == 0) ? 2 : n + 6);
    e.abs_pe  = (s_cyc < 0 || n == 0) ? -1 : s_cyc + 2;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (bus.busy) chk("idle_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  // bub: 0 = op_valid held high, >0 = fixed bubbles between pairs, <0 = random 0..2 bubbles
  task automatic run_job(input int n, input bit relu, input int bub);
    int s_cyc;
    bit hs;
    int t;
    int nb;
    wait_idle();
    bus.start   = 1'b1;
    bus.len     = W_LEN'(n);
    bus.relu_en = relu;
    s_cyc = cyc;
    push_exp(n, relu, (bub == 0) ? s_cyc : -1);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.len     = W_LEN'($urandom);
    bus.relu_en = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      nb = (i == 0) ? 0 : (bub >= 0) ? bub : int'($urandom_range(0, 2));
      repeat (nb) begin
        bus.op_valid = 1'b0;
        bus.op_a = W_IN'($urandom);
        bus.op_b = W_IN'($urandom);
        @(posedge clk); #1;
      end
      bus.op_valid = 1'b1;
      bus.op_a = W_IN'(a_arr[i]);
      bus.op_b = W_IN'(b_arr[i]);
      t = 0;
      do begin
        @(negedge clk); hs = bus.op_ready;
        @(posedge clk); #1; t++;
      end while (!hs && t < 1000);
      if (!hs) chk("op_accept_timeout", {63'd0, hs}, 64'd1);
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic set_ops3(input int a0, a1, a2, b0, b1, b2);
    a_arr[0] = a0; a_arr[1] = a1; a_arr[2] = a2;
    b_arr[0] = b0; b_arr[1] = b1; b_arr[2] = b2;
  endtask

  // Result consumer
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on the first res_valid cycle of each result.
  int pe_cnt = 0, first_pe = -1, last_pe = -1;
  bit in_done = 1'b0;
  logic [W_ACC-1:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pe_cnt = 0; first_pe = -1; in_done = 1'b0;
    end else begin
      if (bus.pe_en) begin
        if (pe_cnt == 0) first_pe = cyc;
        last_pe = cyc;
        pe_cnt++;
      end
      if (bus.res_valid && !in_done) begin
        in_done = 1'b1;
        held = bus.res_data;
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("res_data", 64'(bus.res_data), 64'(e.data));
          chk("pe_en_count", 64'(pe_cnt), 64'(e.npe));
          if (e.npe > 0) chk("res_after_last_pe", 64'(cyc - last_pe), 64'(PE_LAT + 2));
          if (e.abs_res >= 0) chk("res_valid_cycle", 64'(cyc), 64'(e.abs_res));
          if (e.abs_pe >= 0) chk("first_pe_cycle", 64'(first_pe), 64'(e.abs_pe));
        end
        pe_cnt = 0;
        first_pe = -1;
      end
      if (bus.res_valid && in_done && bus.res_ready) begin
        chk("res_data_held", 64'(bus.res_data), 64'(held));
        in_done = 1'b0;
      end
    end
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.len = '0; bus.relu_en = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 8'd9; bus.op_b = 8'd9;
    #2;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_op_ready", {63'd0, bus.op_ready}, 64'd0);
    chk("rst_pe_en", {63'd0, bus.pe_en}, 64'd0);
    chk("rst_reg_reset", {63'd0, bus.reg_reset}, 64'd0);
    chk("rst_mode_sel", {63'd0, bus.mode_sel}, 64'd0);
    chk("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    set_ops3(2, 3, 4, 5, -1, 10);
    run_job(3, 1'b0, 0);                    // dot product 47
    run_job(0, 1'b0, 0);                    // zero length after stale 47
    a_arr[0] = 10; b_arr[0] = -7;
    run_job(1, 1'b1, 0);                    // ReLU clamp -> 0
    run_job(1, 1'b0, 0);                    // -70
    set_ops3(2, 3, 4, 5, -1, 10);
    run_job(3, 1'b0, 2);                    // bubbles

    // Backpressure with an ignored start in DONE
    wait_idle();
    rdy_mode = 2;
    run_job(3, 1'b0, 0);
    t = 0;
    while (!bus.res_valid && t < 100) begin @(posedge clk); #1; t++; end
    if (!bus.res_valid) chk("done_timeout", 64'd0, 64'd1);
    bus.start = 1'b1; bus.len = 8'd5; bus.relu_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("bp_busy", {63'd0, bus.busy}, 64'd1);
    chk("bp_res_valid", {63'd0, bus.res_valid}, 64'd1);
    chk("bp_mode_sel", {63'd0, bus.mode_sel}, 64'd0);
    chk("bp_res_data", 64'(bus.res_data), 64'd47);
    rdy_mode = 0;
    a_arr[0] = 6; a_arr[1] = 7; b_arr[0] = 3; b_arr[1] = -2;
    run_job(2, 1'b0, 0);                    // accepted in first IDLE cycle -> 4
    wait_idle();

    // Reset in the middle of RUN
    bus.start = 1'b1; bus.len = 8'd4; bus.relu_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd3;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_op_ready", {63'd0, bus.op_ready}, 64'd0);
    chk("mid_rst_pe_en", {63'd0, bus.pe_en}, 64'd0);
    chk("mid_rst_reg_reset", {63'd0, bus.reg_reset}, 64'd0);
    chk("mid_rst_mode_sel", {63'd0, bus.mode_sel}, 64'd0);
    chk("mid_rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("mid_rst_res_data", 64'(bus.res_data), 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    reset = 1'b0;
    a_arr[0] = 1; b_arr[0] = 1;
    run_job(1, 1'b0, 0);                    // no residue -> 1

    // Maximum length, then random jobs with random backpressure
    for (int i = 0; i < 255; i++) begin
      a_arr[i] = int'($urandom_range(0, 255));
      b_arr[i] = int'($urandom_range(0, 255)) - 128;
    end
    run_job(255, 1'($urandom), 0);
    rdy_mode = 1;
    for (int j = 0; j < 14; j++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) begin
        a_arr[i] = int'($urandom_range(0, 255));
        b_arr[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_job(n, 1'($urandom), (j % 3 == 0) ? 0 : -1);
    end

    t = 0;
    while ((sb.size() != 0 || bus.busy) && t < 5000) begin @(posedge clk); #1; t++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pe_mac_ctrl.md
PE_MAC_CTRL -- requirements
Module: pe_mac_ctrl

Interface
REQ-001 SHALL have parameters: W_IN, default 8, operand width; W_ACC, default 24, result width; W_LEN, default 8, job-length width; PE_LAT, default 3, pe_core update latency in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  job request pulse; sampled only in IDLE
- len  in  W_LEN  number of products in the job; sampled with start
- relu_en  in  1  job activation select; sampled with start
- busy  out  1  high in every state except IDLE
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted when op_valid && op_ready
- op_a  in  W_IN  unsigned operand
- op_b  in  W_IN  signed operand
- pe_en  out  1  drives pe_core pe_en
- reg_reset  out  1  drives pe_core reg_reset
- mode_sel  out  1  drives pe_core mode_sel
- a_mul  out  W_IN  drives pe_core a_mul
- b_mul  out  W_IN  drives pe_core b_mul
- pe_results  in  W_ACC  pe_core results
- res_valid  out  1  final result valid
- res_ready  in  1  result consumer ready
- res_data  out  W_ACC  final signed result

Function
REQ-003 SHALL implement the FSM states IDLE, CLEAR, RUN, DRAIN and DONE, with the following transitions:
- IDLE -> CLEAR on start.
- CLEAR -> RUN after 1 cycle if len!=0; CLEAR -> DONE if len==0.
- RUN -> DRAIN on the handshake that accepts the len-th operand.
- DRAIN -> DONE after PE_LAT+1 cycles.
- DONE -> IDLE on res_ready.
REQ-004 SHALL assert reg_reset=1 in CLEAR only and hold pe_en=0 in CLEAR.
REQ-005 SHALL drive op_ready=1 only in RUN, as a Moore output.
REQ-006 SHALL drive pe_en = RUN && op_valid, and drive a_mul=op_a and b_mul=op_b combinationally.
REQ-007 SHALL count accepted operands in a W_LEN-bit counter, cleared in CLEAR; len up to 2^W_LEN-1 SHALL complete with no wrap.
REQ-008 SHALL treat op_valid=0 cycles in RUN as bubbles: pe_en=0, and the counter and state are held.
REQ-009 SHALL register relu_en into mode_sel when start is accepted, and hold mode_sel constant until the next accepted start.
REQ-010 SHALL load pe_results into res_data on the last DRAIN cycle, i.e. PE_LAT+1 cycles after the last pe_en cycle.
REQ-011 SHALL load res_data=0 on the CLEAR->DONE transition when len==0, and SHALL NOT sample pe_results in that case.
REQ-012 SHALL hold res_valid=1 and res_data stable throughout DONE until res_valid && res_ready.
REQ-013 SHALL ignore start outside IDLE, with no effect on the running job, len, or mode_sel.
REQ-014 SHALL meet this timing with no bubbles: start accepted in cycle S gives CLEAR in S+1, RUN in S+2..S+N+1, DRAIN in S+N+2..S+N+5, and res_valid in S+N+6, where N=len.
REQ-015 SHALL accept start in the first IDLE cycle after DONE, with no extra dead cycle.

Reset
REQ-016 SHALL, on reset at any time including mid-RUN or mid-DRAIN, go to IDLE immediately.
REQ-017 SHALL drive these reset values: busy, op_ready, pe_en, reg_reset, mode_sel and res_valid = 0; res_data, counter and latched len = 0.
REQ-018 SHALL begin the first job after reset deassertion with CLEAR, with no dependence on pe_core state.

Verification
REQ-019 Three-product dot: len=3, relu_en=0, a=(2,3,4), b=(5,-1,10), op_valid held high -> res_data=47; res_valid in S+9; pe_en high exactly in S+2..S+4.
REQ-020 ReLU clamp: len=1, relu_en=1, a=10, b=-7 -> res_data=0. Same job with relu_en=0 -> res_data=-70 (0xFFFFBA).
REQ-021 Bubbles: len=3, same operands as REQ-019, op_valid low for 2 cycles between each pair -> res_data=47; pe_en pulses exactly 3 times; res_valid 4 cycles after the last pe_en cycle + 1.
REQ-022 Zero length: len=0 after a prior job left pe_results=47 -> res_data=0; res_valid in S+2; pe_en never asserted.
REQ-023 Backpressure and start: res_ready low for 5 cycles with start pulsed during DONE -> res_data held stable, start ignored. After res_ready, a new start in the next IDLE cycle is accepted.
REQ-024 Reset mid-RUN: assert reset after 2 of 4 operands -> all outputs 0 and state IDLE. A subsequent job len=1, a=1, b=1 -> res_data=1, with no residue from the aborted job.
